vga_encode_builder: RTL and testbench
=====================================

# vga_encode_builder

Builds and publishes the 32-bit `encode` word consumed by the VGA shape renderer. It collects per-slot shape/color writes from the CPU-side datapath into a shadow register, or fills all six slots from an internal LFSR. It copies the shadow word to the live `encode` output only at a frame boundary after a commit request, so the display never tears mid-frame.

## Interface
Parameters:
- `LFSR_SEED`, 16'hACE1, reset value of the 16-bit LFSR (must be nonzero).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  slot write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready` at a rising edge; `wr_ready = (state == IDLE)`.
- `wr_slot`  in  3  target slot 0..5.
- `wr_shape`  in  3  shape code (0 blank, 1 up, 2 down, 3 left, 4 right, 5 square).
- `wr_color`  in  2  color code 0..3.
- `wr_err`  out  1  registered one-cycle pulse after an accepted write with `wr_slot` of 6 or 7.
- `rand_req`  in  1  request a random fill of all six slots.
- `commit`  in  1  request that the shadow word be published at the next frame boundary.
- `frame_start`  in  1  one-cycle pulse from VGA timing at start of vertical blanking.
- `encode`  out  32  live word driving the renderer.
- `busy`  out  1  high while in FILL.
- `pending`  out  1  a commit is waiting for a frame boundary.
- `commit_done`  out  1  one-cycle pulse, high in the cycle `encode` holds a newly published value.

## Operation
- Word format, for shadow and `encode`, slot i = 0..5:
  - shape at bits [3i+2:3i].
  - color at bits [21+2i:20+2i].
  - bits [19:18] are always 0.
- Reset values: `encode` = 0, shadow = 0, `pending` = 0, `busy` = 0, `wr_err` = 0, `commit_done` = 0, state = IDLE, LFSR = `LFSR_SEED`, fill counter = 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400). It advances every cycle, including outside FILL.
- States:
  - IDLE: accepts writes.
    - An accepted write with slot ≤5 replaces that slot's shape and color in the shadow.
    - An accepted write with slot 6/7 leaves the shadow unchanged and pulses `wr_err`.
    - `rand_req` sampled high moves the state to FILL with counter = 0.
  - FILL: `wr_ready` = 0 and `rand_req` is ignored.
    - Each edge writes slot `cnt` with shape = (lfsr[2:0] mod 5) + 1 and color = lfsr[4:3], using the LFSR value before that edge's update.
    - `cnt` increments each edge. The edge with `cnt` = 5 writes slot 5 and returns to IDLE.
- Commit:
  - `commit` sampled high sets `pending`. Commits are not counted; repeats while pending are absorbed.
  - Publish condition: `frame_start` && (`pending` || `commit`) && state == IDLE.
  - On publish: `encode` takes the pre-edge shadow value, `pending` clears, and `commit_done` pulses.
  - `frame_start` during FILL with a commit pending: no publish; `pending` holds until a later `frame_start` in IDLE.
- Simultaneous events:
  - Write accepted on the publish edge: `encode` gets the old shadow; the write lands in the shadow only and stays unpublished until the next commit.
  - `rand_req` and an accepted write on the same IDLE edge: the write lands, then FILL overwrites all slots.
- Reset asserted mid-FILL or with a commit pending: all state returns to reset values immediately. The fill is abandoned and `encode` reads 0.

## Timing
- Write latency: shadow updated by the accepting edge; `encode` is unaffected until a publish.
- Publish: `encode` changes on the same edge that samples `frame_start` high; `commit_done` is high for the following cycle only.
- FILL: `busy` high for exactly 6 cycles, starting after the edge that samples `rand_req`. `wr_ready` is low for those same 6 cycles.
- `wr_err` and `commit_done` are registered outputs, one cycle wide. All other outputs are registered, except `wr_ready`, which is decoded from state.
- `encode` is stable between `frame_start` pulses.

## Test plan
- Reset, then idle 10 cycles → `encode` = 32'h0000_0000, `busy` = 0, `pending` = 0, `wr_ready` = 1.
- Write slot 2, shape 5, color 3; pulse `commit`; pulse `frame_start` 5 cycles later → `encode` = 32'h0300_0140, `commit_done` pulses once, `pending` 1→0.
- Write slot 7, shape 1, color 1 → `wr_err` pulses one cycle; shadow unchanged (a later commit with `frame_start` leaves `encode` unchanged).
- Pulse `rand_req`, then assert `commit` and `frame_start` during FILL → `busy` high 6 cycles, `wr_valid` stalled, no publish. The next `frame_start` publishes six nonzero shapes, each in 1..5, with bits [19:18] = 0 and values matching a reference model LFSR seeded with 16'hACE1.
- `commit` and `frame_start` on the same edge as an accepted write to slot 0 (shape 1) → `encode` = prior shadow. A second commit plus `frame_start` then shows slot 0 = 1.
- Assert `rst_n` low mid-FILL with a commit pending → all outputs return to reset values asynchronously. After release, `encode` = 0 and the first random fill reproduces the seed sequence.

Source files
------------

// File: rtl/vga_encode_builder.sv
// Shadow/live encode word builder for the VGA shape renderer.
// Slot writes and LFSR fills land in a shadow word that is published to encode only at a frame boundary.
module vga_encode_builder #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [2:0]  wr_slot,
   input  logic [2:0]  wr_shape,
   input  logic [1:0]  wr_color,
   output logic        wr_err,
   input  logic        rand_req,
   input  logic        commit,
   input  logic        frame_start,
   output logic [31:0] encode,
   output logic        busy,
   output logic        pending,
   output logic        commit_done
);

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned LFSR_W    = 16;
   localparam int unsigned CNT_W     = 3;
   localparam int unsigned NUM_SLOTS = 6;
   localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
   localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(NUM_SLOTS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [WORD_W-1:0]   shadow_q, shadow_d;
   logic [WORD_W-1:0]   encode_d;
   logic                pending_d, busy_d, wr_err_d, commit_done_d;
   logic                publish;
   logic [2:0]          fill_shape;

   // Replace the shape and color fields of one slot; slots 6/7 leave the word untouched.
   function automatic logic [WORD_W-1:0] set_slot(input logic [WORD_W-1:0] word,
                                                   input logic [2:0] slot,
                                                   input logic [2:0] shape,
                                                   input logic [1:0] color);
      logic [WORD_W-1:0] w;
      w = word;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
         if (slot == 3'(i)) begin
            w[3*i +: 3]    = shape;
            w[20+2*i +: 2] = color;
         end
      end
      return w;
   endfunction

   assign lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
   assign fill_shape = 3'((lfsr_q[2:0] % 3'd5) + 3'd1);
   assign wr_ready   = (state_q == IDLE);

   // Next-state and next-output decode.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shadow_d      = shadow_q;
      encode_d      = encode;
      pending_d     = pending | commit;
      wr_err_d      = 1'b0;
      commit_done_d = 1'b0;
      publish       = frame_start && (pending || commit) && (state_q == IDLE);

      if (publish) begin
         encode_d      = shadow_q;
         pending_d     = 1'b0;
         commit_done_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (wr_valid) begin
               if (wr_slot <= LAST_SLOT) shadow_d = set_slot(shadow_q, wr_slot, wr_shape, wr_color);
               else                      wr_err_d = 1'b1;
            end
            if (rand_req) begin
               state_d = FILL;
               cnt_d   = '0;
            end
         end
         FILL: begin
            shadow_d = set_slot(shadow_q, cnt_q, fill_shape, lfsr_q[4:3]);
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_SLOT) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == FILL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         shadow_q    <= '0;
         encode      <= '0;
         pending     <= 1'b0;
         busy        <= 1'b0;
         wr_err      <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lfsr_q      <= lfsr_d;
         shadow_q    <= shadow_d;
         encode      <= encode_d;
         pending     <= pending_d;
         busy        <= busy_d;
         wr_err      <= wr_err_d;
         commit_done <= commit_done_d;
      end
   end

endmodule

// File: tb/tb_vga_encode_builder.sv
// Directed bench for vga_encode_builder: expected published words are queued when stimulus is driven
// and compared when commit_done reports a publish.
module tb_vga_encode_builder;

   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid, wr_ready;
   logic [2:0]  wr_slot, wr_shape;
   logic [1:0]  wr_color;
   logic        wr_err, rand_req, commit, frame_start;
   logic [31:0] encode;
   logic        busy, pending, commit_done;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [31:0] sb[$];
   logic [31:0] exp_shadow;
   logic [15:0] m_lfsr;

   vga_encode_builder #(.LFSR_SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
      .wr_shape(wr_shape), .wr_color(wr_color), .wr_err(wr_err),
      .rand_req(rand_req), .commit(commit), .frame_start(frame_start),
      .encode(encode), .busy(busy), .pending(pending), .commit_done(commit_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [2:0] shape_of(input logic [2:0] v);
      logic [2:0] tbl [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3};
      return tbl[v];
   endfunction

   // One clock: the reference LFSR free-runs alongside the DUT while out of reset.
   task automatic tick();
      @(posedge clk);
      if (rst_n) m_lfsr = lfsr_step(m_lfsr);
      @(negedge clk);
   endtask

   task automatic model_write(input int slot, input logic [2:0] shape, input logic [1:0] color);
      exp_shadow[3*slot +: 3]    = shape;
      exp_shadow[20+2*slot +: 2] = color;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 4 && sb.size() != 0; i++) tick();
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_shapes(input string tag);
      for (int i = 0; i < 6; i++)
         check(tag, 32'(encode[3*i +: 3] >= 3'd1 && encode[3*i +: 3] <= 3'd5), 32'd1);
      check({tag, "_pad"}, 32'(encode[19:18]), 32'd0);
   endtask

   // Scoreboard consumer: every publish must have been predicted.
   always @(negedge clk) begin
      if (commit_done) begin
         if (sb.size() == 0) check("spurious_commit_done", 32'(commit_done), 32'd0);
         else                check("publish_word", encode, sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; wr_valid = 1'b0; wr_slot = '0; wr_shape = '0; wr_color = '0;
      rand_req = 1'b0; commit = 1'b0; frame_start = 1'b0;
      exp_shadow = '0; m_lfsr = SEED;
      repeat (3) @(negedge clk);
      check("rst_encode", encode, 32'h0);
      rst_n = 1'b1;
      repeat (10) tick();
      check("idle_encode", encode, 32'h0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_pending", 32'(pending), 32'd0);
      check("idle_wr_ready", 32'(wr_ready), 32'd1);

      // Slot write, commit, publish five cycles later
      wr_valid = 1'b1; wr_slot = 3'd2; wr_shape = 3'd5; wr_color = 2'd3;
      model_write(2, 3'd5, 2'd3);
      tick();
      wr_valid = 1'b0;
      check("write_no_publish", encode, 32'h0);
      commit = 1'b1; tick(); commit = 1'b0;
      check("pending_set", 32'(pending), 32'd1);
      repeat (5) tick();
      check("pending_held", 32'(pending), 32'd1);
      sb.push_back(exp_shadow);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("publish_const", encode, 32'h0300_0140);
      check("publish_commit_done", 32'(commit_done), 32'd1);
      check("pending_cleared", 32'(pending), 32'd0);
      drain("drain_first");
      check("commit_done_one_cycle", 32'(commit_done), 32'd0);

      // Out-of-range slot
      wr_valid = 1'b1; wr_slot = 3'd7; wr_shape = 3'd1; wr_color = 2'd1;
      tick();
      wr_valid = 1'b0;
      check("wr_err_pulse", 32'(wr_err), 32'd1);
      tick();
      check("wr_err_clear", 32'(wr_err), 32'd0);
      sb.push_back(exp_shadow);
      commit = 1'b1; frame_start = 1'b1; tick(); commit = 1'b0; frame_start = 1'b0;
      check("bad_slot_encode", encode, 32'h0300_0140);
      drain("drain_bad_slot");

      // Random fill with commit/frame_start and stalled writes during FILL
      rand_req = 1'b1; tick(); rand_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("fill_busy", 32'(busy), 32'd1);
         check("fill_wr_ready", 32'(wr_ready), 32'd0);
         if (k == 3) check("fill_pending", 32'(pending), 32'd1);
         model_write(k, shape_of(m_lfsr[2:0]), m_lfsr[4:3]);
         wr_valid    = (k >= 1);
         wr_slot     = 3'd0; wr_shape = 3'd0; wr_color = 2'd0;
         commit      = (k == 2);
         frame_start = (k == 2);
         rand_req    = (k == 4);
         tick();
      end
      wr_valid = 1'b0; commit = 1'b0; frame_start = 1'b0; rand_req = 1'b0;
      check("fill_done_busy", 32'(busy), 32'd0);
      check("fill_no_publish", encode, 32'h0300_0140);
      check("fill_pending_kept", 32'(pending), 32'd1);
      sb.push_back(exp_shadow);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      check("fill_publish", encode, exp_shadow);
      check_shapes("fill_shape_range");
      drain("drain_fill");

      // Write on the publish edge stays in the shadow only
      sb.push_back(exp_shadow);
      wr_valid = 1'b1; wr_slot = 3'd0; wr_shape = 3'd1; wr_color = 2'd0;
      commit = 1'b1; frame_start = 1'b1;
      model_write(0, 3'd1, 2'd0);
      tick();
      wr_valid = 1'b0; commit = 1'b0; frame_start = 1'b0;
      drain("drain_same_edge");
      sb.push_back(exp_shadow);
      commit = 1'b1; frame_start = 1'b1; tick(); commit = 1'b0; frame_start = 1'b0;
      check("slot0_shape", 32'(encode[2:0]), 32'd1);
      drain("drain_second");

      // Asynchronous reset mid-FILL with a commit pending
      rand_req = 1'b1; tick(); rand_req = 1'b0;
      tick();
      commit = 1'b1; tick(); commit = 1'b0;
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_encode", encode, 32'h0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_pending", 32'(pending), 32'd0);
      check("arst_wr_ready", 32'(wr_ready), 32'd1);
      check("arst_wr_err", 32'(wr_err), 32'd0);
      check("arst_commit_done", 32'(commit_done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; m_lfsr = SEED; exp_shadow = '0;
      check("post_reset_encode", encode, 32'h0);
      rand_req = 1'b1; tick(); rand_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
         model_write(k, shape_of(m_lfsr[2:0]), m_lfsr[4:3]);
         tick();
      end
      check("refill_busy", 32'(busy), 32'd0);
      sb.push_back(exp_shadow);
      commit = 1'b1; frame_start = 1'b1; tick(); commit = 1'b0; frame_start = 1'b0;
      check("refill_publish", encode, exp_shadow);
      check_shapes("refill_shape_range");
      drain("drain_refill");

      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
